// File: rtl/fifo_pcie.sv
// fifo_pcie: synchronous circular-buffer FIFO with occupancy thresholds and sticky error flags
module fifo_pcie #(
  parameter int DATA_WIDTH      = 12,
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow_err,
  output logic                  underflow_err
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  always_comb begin
    full         = count == (ADDR_WIDTH+1)'(DEPTH);
    empty        = count == '0;
    almost_full  = count >= (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
    almost_empty = count <= (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);
    do_pop       = pop && !empty;
    do_push      = push && (!full || do_pop);
  end
  // storage is never cleared; reset only blocks the write
  always_ff @(posedge clk)
    if (reset && do_push) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      data_out      <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (do_pop) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
      end
      count <= count + (ADDR_WIDTH+1)'(do_push) - (ADDR_WIDTH+1)'(do_pop);
      if (push && full && !pop) overflow_err <= 1'b1;
      if (pop && empty) underflow_err <= 1'b1;
    end
  end
endmodule
